// File: rtl/conv_window_gen_if.sv
// -----------------------------------------------------------------------------
// conv_window_gen_if
// Groups the pixel input stream and the window output stream of the
// convolution window generator.
//
// Handshake: in_valid/in_pixel is a valid-only stream. The pixel is accepted
// on every rising clock edge where in_valid is high, and there is no ready
// signal. On the output side, out_valid marks the single cycle in which
// window/out_row/out_col/frame_done describe a complete in-image window.
// The consumer must take it in that cycle.
//
// Signals:
//   in_valid   - pixel on in_pixel is valid this cycle
//   in_pixel   - raster-order pixel, BIT_WIDTH bits
//   out_valid  - window holds a complete in-image window
//   window     - packed K x K window, element (r,c) at (r*K+c)*BIT_WIDTH
//   out_row    - image row of the window's bottom-right pixel
//   out_col    - image column of the window's bottom-right pixel
//   frame_done - pulses together with the last window of a frame
// Modports: master = pixel source / window sink, slave = generator.
// -----------------------------------------------------------------------------
interface conv_window_gen_if #(
  parameter int COL       = 5,
  parameter int ROW       = 5,
  parameter int K         = 3,
  parameter int BIT_WIDTH = 8
);
  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;

  logic                       in_valid;
  logic [BIT_WIDTH-1:0]       in_pixel;
  logic                       out_valid;
  logic [K*K*BIT_WIDTH-1:0]   window;
  logic [RW-1:0]              out_row;
  logic [CW-1:0]              out_col;
  logic                       frame_done;

  modport master (
    output in_valid, in_pixel,
    input  out_valid, window, out_row, out_col, frame_done
  );

  modport slave (
    input  in_valid, in_pixel,
    output out_valid, window, out_row, out_col, frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
// Consumes a raster-order pixel stream and presents a K x K sliding window.
// K-1 image rows are held in COL-deep shift delay lines that advance only on
// accepted pixels. A K x K register array holds the window. Row and column
// counters track the position of the incoming pixel. out_valid is raised one
// cycle after a pixel whose window lies fully inside the image.
//
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   io  - conv_window_gen_if.slave (pixel stream in, window stream out)
// -----------------------------------------------------------------------------
module conv_window_gen #(
  parameter int COL       = 5,
  parameter int ROW       = 5,
  parameter int K         = 3,
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_window_gen_if.slave     io
);

  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;

  logic [CW-1:0]        col_cnt_q, col_cnt_d;
  logic [RW-1:0]        row_cnt_q, row_cnt_d;
  logic [RW-1:0]        out_row_q, out_row_d;
  logic [CW-1:0]        out_col_q, out_col_d;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic [BIT_WIDTH-1:0] win_q [K][K];
  logic [BIT_WIDTH-1:0] win_d [K][K];
  // Line i feeds line i+1; element COL-1 is the oldest pixel of each line.
  logic [BIT_WIDTH-1:0] line_q [K-1][COL];
  logic [K*K*BIT_WIDTH-1:0] window_packed;

  logic col_last;
  logic row_last;
  logic in_image;

  assign col_last = (col_cnt_q == CW'(COL - 1));
  assign row_last = (row_cnt_q == RW'(ROW - 1));
  // Suppresses both the first K-1 rows and the row-wrap windows.
  assign in_image = (row_cnt_q >= RW'(K - 1)) && (col_cnt_q >= CW'(K - 1));

  always_comb begin
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    win_d        = win_q;

    if (io.in_valid) begin
      if (col_last) begin
        col_cnt_d = '0;
        row_cnt_d = row_last ? '0 : row_cnt_q + RW'(1);
      end else begin
        col_cnt_d = col_cnt_q + CW'(1);
      end

      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      // New right-hand column: the oldest line sits on top, the live pixel at the bottom.
      for (int r = 0; r < K - 1; r++) begin
        win_d[r][K-1] = line_q[K-2-r][COL-1];
      end
      win_d[K-1][K-1] = io.in_pixel;

      out_row_d    = row_cnt_q;
      out_col_d    = col_cnt_q;
      out_valid_d  = in_image;
      frame_done_d = in_image && col_last && row_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line storage is not reset. After a reset, the counters force K-1 full
  // rows of fresh pixels through the lines before any window is flagged valid.
  always_ff @(posedge clk) begin
    if (io.in_valid) begin
      for (int i = 0; i < K - 1; i++) begin
        line_q[i][0] <= (i == 0) ? io.in_pixel : line_q[i-1][COL-1];
        for (int j = 1; j < COL; j++) begin
          line_q[i][j] <= line_q[i][j-1];
        end
      end
    end
  end

  always_comb begin
    window_packed = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        window_packed[(r*K+c)*BIT_WIDTH +: BIT_WIDTH] = win_q[r][c];
      end
    end
  end

  assign io.out_valid  = out_valid_q;
  assign io.frame_done = frame_done_q;
  assign io.out_row    = out_row_q;
  assign io.out_col    = out_col_q;
  assign io.window     = window_packed;

endmodule

// File: tb/tb_conv_window_gen.sv
// -----------------------------------------------------------------------------
// tb_conv_window_gen
// Directed bench for conv_window_gen (COL=ROW=5, K=3, 8-bit pixels).
// The driver records every pixel in an image model. For each in-image
// position it pushes the expected window, coordinates and frame_done into
// exp_q. A negedge monitor pops and compares each window the DUT presents.
// -----------------------------------------------------------------------------
module tb_conv_window_gen;

  localparam int COL = 5;
  localparam int ROW = 5;
  localparam int K   = 3;
  localparam int BW  = 8;
  localparam int WW  = K * K * BW;
  localparam int CW  = $clog2(COL);
  localparam int RW  = $clog2(ROW);
  localparam int EW  = 1 + RW + CW + WW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_window_gen_if #(.COL(COL), .ROW(ROW), .K(K), .BIT_WIDTH(BW)) bus ();

  conv_window_gen #(.COL(COL), .ROW(ROW), .K(K), .BIT_WIDTH(BW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  logic [WW-1:0] seen_q[$];
  logic [EW-1:0] mon_e;
  int win_cnt = 0;
  int fd_cnt  = 0;
  logic acc_prev = 1'b0;
  int img [ROW][COL];
  int m_row = 0;
  int m_col = 0;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [WW-1:0] model_win(input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        w[(i*K+j)*BW +: BW] = BW'(img[r-K+1+i][c-K+1+j]);
      end
    end
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input int p);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_pixel = BW'(p);
    img[m_row][m_col] = p;
    if (m_row >= K - 1 && m_col >= K - 1) begin
      exp_q.push_back({(m_row == ROW - 1 && m_col == COL - 1) ? 1'b1 : 1'b0,
                       RW'(m_row), CW'(m_col), model_win(m_row, m_col)});
    end
    if (m_col == COL - 1) begin
      m_col = 0;
      m_row = (m_row == ROW - 1) ? 0 : m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) idle();
    chk("exp_q_drained", WW'(exp_q.size()), WW'(0));
  endtask

  task automatic clear_stats();
    win_cnt = 0;
    fd_cnt  = 0;
    seen_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"},  WW'(bus.out_valid),  WW'(0));
    chk({tag, "_frame_done"}, WW'(bus.frame_done), WW'(0));
    chk({tag, "_window"},     bus.window,          WW'(0));
    chk({tag, "_out_row"},    WW'(bus.out_row),    WW'(0));
    chk({tag, "_out_col"},    WW'(bus.out_col),    WW'(0));
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) acc_prev <= bus.in_valid && !rst;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid === 1'b1) begin
        chk("valid_after_accept", WW'(acc_prev), WW'(1));
        chk("window_expected", WW'(exp_q.size() > 0), WW'(1));
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("window",     bus.window,          mon_e[WW-1:0]);
          chk("out_col",    WW'(bus.out_col),    WW'(mon_e[WW+CW-1:WW]));
          chk("out_row",    WW'(bus.out_row),    WW'(mon_e[WW+CW+RW-1:WW+CW]));
          chk("frame_done", WW'(bus.frame_done), WW'(mon_e[EW-1]));
        end
        win_cnt++;
        if (bus.frame_done === 1'b1) fd_cnt++;
        seen_q.push_back(bus.window);
      end else begin
        chk("frame_done_idle", WW'(bus.frame_done), WW'(0));
      end
    end
  end

  // ---------------- directed sequence ----------------
  logic [WW-1:0] w_first;
  logic [WW-1:0] w_row3;
  logic [WW-1:0] w_last;
  logic [WW-1:0] w_rst_first;
  logic [WW-1:0] w_b_first;

  initial begin
    w_first     = {8'd13, 8'd12, 8'd11, 8'd8, 8'd7, 8'd6, 8'd3, 8'd2, 8'd1};
    w_row3      = {8'd18, 8'd17, 8'd16, 8'd13, 8'd12, 8'd11, 8'd8, 8'd7, 8'd6};
    w_last      = {8'd25, 8'd24, 8'd23, 8'd20, 8'd19, 8'd18, 8'd15, 8'd14, 8'd13};
    w_rst_first = {8'd113, 8'd112, 8'd111, 8'd108, 8'd107, 8'd106, 8'd103, 8'd102, 8'd101};
    w_b_first   = {8'd38, 8'd37, 8'd36, 8'd33, 8'd32, 8'd31, 8'd28, 8'd27, 8'd26};

    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single continuous frame
    clear_stats();
    for (int p = 1; p <= 25; p++) send(p);
    drain();
    chk("f1_windows",     WW'(win_cnt), WW'(9));
    chk("f1_frame_done",  WW'(fd_cnt),  WW'(1));
    chk("f1_first_win",   seen_q[0],    w_first);
    chk("f1_row3_win",    seen_q[3],    w_row3);
    chk("f1_last_win",    seen_q[8],    w_last);

    // Same frame with random bubbles
    clear_stats();
    for (int p = 1; p <= 25; p++) begin
      if ($urandom_range(0, 1) == 1) idle();
      if ($urandom_range(0, 3) == 0) idle();
      send(p);
    end
    drain();
    chk("bub_windows",    WW'(win_cnt), WW'(9));
    chk("bub_frame_done", WW'(fd_cnt),  WW'(1));
    chk("bub_first_win",  seen_q[0],    w_first);
    chk("bub_last_win",   seen_q[8],    w_last);

    // Reset in the middle of a frame
    clear_stats();
    for (int p = 1; p <= 14; p++) send(p);
    drain();
    rst = 1'b1;
    m_row = 0;
    m_col = 0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    clear_stats();
    for (int p = 101; p <= 125; p++) send(p);
    drain();
    chk("rst_windows",    WW'(win_cnt), WW'(9));
    chk("rst_frame_done", WW'(fd_cnt),  WW'(1));
    chk("rst_first_win",  seen_q[0],    w_rst_first);

    // Back-to-back frames
    clear_stats();
    for (int p = 1; p <= 50; p++) send(p);
    drain();
    chk("b2b_windows",    WW'(win_cnt), WW'(18));
    chk("b2b_frame_done", WW'(fd_cnt),  WW'(2));
    chk("b2b_a_first",    seen_q[0],    w_first);
    chk("b2b_b_first",    seen_q[9],    w_b_first);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
